sink: RTL and testbench

- Receiving end of the two-phase (transition-signalling) req/ack link driven by traffic sources in the NoC testbench.
- Detects each req toggle and captures the flit into a small FIFO. Acknowledges with an ack toggle.
- Drains the FIFO at a programmable rate to model a slow consumer and create back-pressure.
- Checks each drained flit against an expected payload and keeps receive statistics.

---
 rtl/sink.sv | 155 +++++++++++++++
 tb/tb_sink.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sink.sv
// Receiving end of a two-phase req/ack link. Each req transition delivers one flit, which is
// captured into a small FIFO and acknowledged with an ack transition. The FIFO drains at a
// programmable rate, and every drained flit is checked against a fixed expected payload.
module sink #(
  parameter int unsigned ID           = 0,
  parameter int unsigned SIZE         = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DRAIN_PERIOD = 1,
  parameter int unsigned EXPECTED     = 4,
  parameter bit          CHECK        = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic [SIZE-1:0] data,
  output logic            ack,
  output logic [7:0]      count,
  output logic [SIZE-1:0] last_data,
  output logic            error,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned OccW   = PtrW + 1;
  localparam int unsigned DrainW = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;

  localparam logic [OccW-1:0]   OccFull    = OccW'(DEPTH);
  localparam logic [DrainW-1:0] DrainLast  = DrainW'(DRAIN_PERIOD - 1);
  localparam logic [SIZE-1:0]   ExpPayload = SIZE'(EXPECTED);

  // ID only labels log output in simulation; keep it referenced so it is not flagged as unused.
  logic unused_id;
  assign unused_id = ^ID;

  // Input stage: req/data are registered before use, so accept happens one edge after the toggle.
  logic            req_q, req_d;
  logic [SIZE-1:0] data_q, data_d;

  logic            req_seen_q, req_seen_d;
  logic            ack_q, ack_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [7:0]      count_q, count_d;
  logic [SIZE-1:0] last_q, last_d;
  logic            error_q, error_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;

  logic [SIZE-1:0] mem_q [DEPTH];

  logic            pending;
  logic            accept;
  logic            pop;
  logic [SIZE-1:0] head;

  // Accept/pop decisions are taken on pre-edge occupancy: no write-through into a full FIFO.
  always_comb begin
    pending = req_q ^ req_seen_q;
    accept  = pending && (occ_q != OccFull);
    pop     = (drain_q == DrainLast) && (occ_q != '0);
    head    = mem_q[rptr_q];
  end

  // Next-state logic for the handshake, FIFO bookkeeping, drain timer and statistics.
  always_comb begin
    req_d      = req;
    data_d     = data;
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    drain_d    = (drain_q == DrainLast) ? '0 : drain_q + 1'b1;
    count_d    = count_q;
    last_d     = last_q;
    error_d    = error_q;

    if (accept) begin
      req_seen_d = req_q;
      ack_d      = ~ack_q;
      wptr_d     = wptr_q + 1'b1;
    end

    if (pop) begin
      rptr_d = rptr_q + 1'b1;
      last_d = head;
      if (count_q != 8'hFF) begin
        count_d = count_q + 1'b1;
      end
      if (CHECK && (head != ExpPayload)) begin
        error_d = 1'b1;
      end
    end

    unique case ({accept, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    empty_d = (occ_d == '0);
    full_d  = (occ_d == OccFull);
  end

  // State registers with synchronous active-low reset; reset drops buffered and pending flits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_q      <= 1'b0;
      data_q     <= '0;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      drain_q    <= '0;
      count_q    <= '0;
      last_q     <= '0;
      error_q    <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      req_q      <= req_d;
      data_q     <= data_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      drain_q    <= drain_d;
      count_q    <= count_d;
      last_q     <= last_d;
      error_q    <= error_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      mem_q[wptr_q] <= data_q;
    end
  end

  assign ack       = ack_q;
  assign count     = count_q;
  assign last_data = last_q;
  assign error     = error_q;
  assign empty     = empty_q;
  assign full      = full_q;

endmodule

// File: tb/tb_sink.sv
// Bench for sink: three instances with different depth/drain/check settings, a queue-based
// reference model checked every cycle, a directed vector table and hand-written corner cases.
module tb_sink;

  localparam int NI = 3;
  localparam int DEP [NI] = '{4, 2, 4};
  localparam int PER [NI] = '{1, 8, 16};
  localparam bit CHK [NI] = '{1'b1, 1'b0, 1'b1};
  localparam logic [7:0] EXPV = 8'd4;

  logic clk;
  logic reset;
  logic [NI-1:0]      req_v;
  logic [NI-1:0][7:0] data_v;
  logic [NI-1:0]      ack_v;
  logic [NI-1:0][7:0] count_v;
  logic [NI-1:0][7:0] last_v;
  logic [NI-1:0]      err_v;
  logic [NI-1:0]      empty_v;
  logic [NI-1:0]      full_v;

  int n_checks = 0;
  int n_fail   = 0;

  sink #(.ID(0), .SIZE(8), .DEPTH(4), .DRAIN_PERIOD(1), .EXPECTED(4), .CHECK(1'b1)) u_fast (
    .clk(clk), .reset(reset), .req(req_v[0]), .data(data_v[0]), .ack(ack_v[0]),
    .count(count_v[0]), .last_data(last_v[0]), .error(err_v[0]), .empty(empty_v[0]),
    .full(full_v[0])
  );

  sink #(.ID(1), .SIZE(8), .DEPTH(2), .DRAIN_PERIOD(8), .EXPECTED(4), .CHECK(1'b0)) u_slow (
    .clk(clk), .reset(reset), .req(req_v[1]), .data(data_v[1]), .ack(ack_v[1]),
    .count(count_v[1]), .last_data(last_v[1]), .error(err_v[1]), .empty(empty_v[1]),
    .full(full_v[1])
  );

  sink #(.ID(2), .SIZE(8), .DEPTH(4), .DRAIN_PERIOD(16), .EXPECTED(4), .CHECK(1'b1)) u_mid (
    .clk(clk), .reset(reset), .req(req_v[2]), .data(data_v[2]), .ack(ack_v[2]),
    .count(count_v[2]), .last_data(last_v[2]), .error(err_v[2]), .empty(empty_v[2]),
    .full(full_v[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- reference model
  // Behavioural view: a queue of flits, a sampled copy of the link inputs, and a count of
  // edges since reset that decides when a pop opportunity occurs.
  logic [7:0] mq [NI][$];
  bit         m_sreq  [NI];
  logic [7:0] m_sdata [NI];
  bit         m_seen  [NI];
  bit         m_ack   [NI];
  int         m_k     [NI];
  int         m_cnt   [NI];
  logic [7:0] m_last  [NI];
  bit         m_err   [NI];
  bit         model_ok = 1'b0;

  always @(posedge clk) begin
    bit         do_pop;
    bit         do_acc;
    logic [7:0] h;
    for (int i = 0; i < NI; i++) begin
      if (!reset) begin
        mq[i].delete();
        m_sreq[i] = 1'b0; m_sdata[i] = 8'd0; m_seen[i] = 1'b0; m_ack[i] = 1'b0;
        m_k[i] = 0; m_cnt[i] = 0; m_last[i] = 8'd0; m_err[i] = 1'b0;
      end else begin
        do_pop = ((m_k[i] % PER[i]) == PER[i] - 1) && (mq[i].size() > 0);
        do_acc = (m_sreq[i] != m_seen[i]) && (mq[i].size() < DEP[i]);
        if (do_pop) begin
          h = mq[i].pop_front();
          m_last[i] = h;
          if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
          if (CHK[i] && h != EXPV) m_err[i] = 1'b1;
        end
        if (do_acc) begin
          mq[i].push_back(m_sdata[i]);
          m_seen[i] = m_sreq[i];
          m_ack[i]  = ~m_ack[i];
        end
        m_sreq[i]  = req_v[i];
        m_sdata[i] = data_v[i];
        m_k[i]     = m_k[i] + 1;
      end
    end
    if (!reset) model_ok = 1'b1;
  end

  // ---------------------------------------------------------------- helpers
  logic [7:0] txq  [NI][$];
  int         rate [NI];

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Drive sources at the current negedge, pass one rising edge, compare at the next negedge.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < NI; i++) begin
        if (txq[i].size() > 0 && req_v[i] == ack_v[i] && $urandom_range(99) < rate[i]) begin
          req_v[i]  = ~req_v[i];
          data_v[i] = txq[i].pop_front();
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (model_ok) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("model ack[%0d]", i),   ack_v[i],   m_ack[i]);
        chk($sformatf("model count[%0d]", i), count_v[i], m_cnt[i]);
        chk($sformatf("model last[%0d]", i),  last_v[i],  m_last[i]);
        chk($sformatf("model error[%0d]", i), err_v[i],   m_err[i]);
        chk($sformatf("model empty[%0d]", i), empty_v[i], mq[i].size() == 0);
        chk($sformatf("model full[%0d]", i),  full_v[i],  mq[i].size() == DEP[i]);
      end
    end
  endtask

  task automatic apply_reset(int n);
    reset  = 1'b0;
    req_v  = '0;
    data_v = '0;
    for (int i = 0; i < NI; i++) begin
      txq[i].delete();
      rate[i] = 100;
    end
    repeat (n) tick();
    reset = 1'b1;
  endtask

  task automatic wait_idle(int i, int budget, string name);
    int n = 0;
    while ((txq[i].size() > 0 || mq[i].size() > 0 || req_v[i] != ack_v[i]) && n < budget) begin
      tick();
      n++;
    end
    chk({name, " drain within budget"}, n < budget, 1);
  endtask

  // ---------------------------------------------------------------- directed vectors
  typedef struct {
    logic       rst;
    logic       req;
    logic [7:0] data;
    logic       ack;
    int         cnt;
    logic [7:0] last;
    logic       err;
    logic       empty;
    logic       full;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int toggles;
    bit prev_ack;
    bit full_seen;

    tbl[0]  = '{1'b0, 1'b0, 8'd0, 1'b0, 0, 8'd0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'd0, 1'b0, 0, 8'd0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'd4, 1'b0, 0, 8'd0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'd4, 1'b1, 0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'd4, 1'b1, 1, 8'd4, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'd4, 1'b1, 1, 8'd4, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'd4, 1'b0, 1, 8'd4, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'd4, 1'b0, 2, 8'd4, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'd7, 1'b0, 2, 8'd4, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'd7, 1'b1, 2, 8'd4, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'd7, 1'b1, 3, 8'd7, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'd0, 1'b0, 0, 8'd0, 1'b0, 1'b1, 1'b0};

    reset  = 1'b0;
    req_v  = '0;
    data_v = '0;
    for (int i = 0; i < NI; i++) rate[i] = 100;

    // Single flit, reset behaviour and a mismatching payload on the fast instance.
    for (int r = 0; r < 12; r++) begin
      reset     = tbl[r].rst;
      req_v[0]  = tbl[r].req;
      data_v[0] = tbl[r].data;
      tick();
      chk($sformatf("tbl[%0d].ack", r),   ack_v[0],   tbl[r].ack);
      chk($sformatf("tbl[%0d].count", r), count_v[0], tbl[r].cnt);
      chk($sformatf("tbl[%0d].last", r),  last_v[0],  tbl[r].last);
      chk($sformatf("tbl[%0d].error", r), err_v[0],   tbl[r].err);
      chk($sformatf("tbl[%0d].empty", r), empty_v[0], tbl[r].empty);
      chk($sformatf("tbl[%0d].full", r),  full_v[0],  tbl[r].full);
    end

    // Back-to-back source, 6 flits, depth 4, pop every cycle.
    apply_reset(2);
    for (int n = 0; n < 6; n++) txq[0].push_back(EXPV);
    toggles = 0; full_seen = 1'b0; prev_ack = ack_v[0];
    for (int n = 0; n < 100 && (txq[0].size() > 0 || req_v[0] != ack_v[0] || !empty_v[0]); n++) begin
      tick();
      if (ack_v[0] != prev_ack) toggles++;
      prev_ack  = ack_v[0];
      full_seen = full_seen | full_v[0];
    end
    chk("b2b ack toggles", toggles, 6);
    chk("b2b final ack", ack_v[0], 0);
    chk("b2b count", count_v[0], 6);
    chk("b2b error", err_v[0], 0);
    chk("b2b full never", full_seen, 0);

    // Back-pressure: depth 2, pop every 8 cycles, 5 flits.
    apply_reset(2);
    for (int n = 0; n < 5; n++) txq[1].push_back(EXPV);
    repeat (4) tick();
    chk("bp full after 2nd accept", full_v[1], 1);
    chk("bp ack after 2nd accept", ack_v[1], 0);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("bp ack held %0d", n), ack_v[1], 0);
    end
    tick();
    chk("bp 3rd ack after first pop", ack_v[1], 1);
    chk("bp full again", full_v[1], 1);
    wait_idle(1, 200, "bp");
    chk("bp count", count_v[1], 5);
    chk("bp final ack", ack_v[1], 1);
    chk("bp empty", empty_v[1], 1);

    // Accept and pop on the same edge with one flit already buffered.
    apply_reset(2);
    txq[1].push_back(8'h11);
    repeat (6) tick();
    txq[1].push_back(8'h22);
    repeat (2) tick();
    chk("sim count", count_v[1], 1);
    chk("sim popped older", last_v[1], 8'h11);
    chk("sim ack", ack_v[1], 0);
    chk("sim empty", empty_v[1], 0);
    chk("sim full", full_v[1], 0);
    repeat (8) tick();
    chk("sim count2", count_v[1], 2);
    chk("sim newer next", last_v[1], 8'h22);
    chk("sim empty2", empty_v[1], 1);

    // Mismatch 4,7,4: sticky on the checking instance, ignored with checking disabled.
    apply_reset(2);
    for (int i = 0; i < 2; i++) begin
      txq[i].push_back(8'd4); txq[i].push_back(8'd7); txq[i].push_back(8'd4);
    end
    wait_idle(0, 100, "mm0");
    wait_idle(1, 100, "mm1");
    chk("mm error", err_v[0], 1);
    chk("mm count", count_v[0], 3);
    chk("mm last", last_v[0], 4);
    chk("mm nocheck error", err_v[1], 0);
    chk("mm nocheck count", count_v[1], 3);

    // Reset with three flits buffered on the slow-drain instance.
    apply_reset(2);
    for (int n = 0; n < 3; n++) txq[2].push_back(8'd9);
    repeat (8) tick();
    chk("rst buffered count", count_v[2], 0);
    chk("rst buffered empty", empty_v[2], 0);
    chk("rst buffered ack", ack_v[2], 1);
    apply_reset(1);
    chk("rst ack", ack_v[2], 0);
    chk("rst count", count_v[2], 0);
    chk("rst empty", empty_v[2], 1);
    chk("rst error", err_v[2], 0);
    txq[2].push_back(8'd4);
    repeat (2) tick();
    chk("rst reaccept ack", ack_v[2], 1);
    chk("rst reaccept empty", empty_v[2], 0);

    // Randomized traffic against the model; the fast instance runs past count saturation.
    for (int round = 0; round < 2; round++) begin
      apply_reset(1 + $urandom_range(2));
      for (int i = 0; i < NI; i++) begin
        int nf;
        rate[i] = 20 + $urandom_range(80);
        nf = (i == 0) ? 260 : 30;
        for (int n = 0; n < nf; n++) begin
          txq[i].push_back(($urandom_range(1) == 1) ? EXPV : 8'($urandom));
        end
      end
      for (int i = 0; i < NI; i++) wait_idle(i, 8000, $sformatf("rnd%0d[%0d]", round, i));
    end
    chk("saturated count", count_v[0], 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
